clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/clk_gate_ctrl.sv | 100 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and widths for the clock-gate enable controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    StGated  = 2'd0,
    StWake   = 2'd1,
    StActive = 2'd2,
    StHold   = 2'd3
  } state_e;

  // Wake counter covers WAKE_CYC 1..15, idle counter covers IDLE_CYC 1..255.
  localparam int unsigned WakeCntW = 4;
  localparam int unsigned IdleCntW = 8;
  localparam int unsigned GateCntW = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones once full.
module sat_counter
  import clk_gate_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                INC,
  output logic [GateCntW-1:0] CNT
);

  logic [GateCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != {GateCntW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Request-driven clock-enable controller: wake delay, idle hold-off, override and gate counting.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  input  logic                FORCE_ON,
  output logic                CLK_EN,
  output logic                RDY,
  output logic [GateCntW-1:0] GATE_CNT
);

  localparam logic [WakeCntW-1:0] WakeLoad = WakeCntW'(WAKE_CYC - 1);
  localparam logic [IdleCntW-1:0] IdleLoad = IdleCntW'(IDLE_CYC - 1);

  state_e              state_q, state_d;
  logic [WakeCntW-1:0] wake_cnt_q, wake_cnt_d;
  logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                rdy_q, rdy_d;
  logic                gate_inc;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      StGated: begin
        if (REQ) begin
          state_d    = StWake;
          wake_cnt_d = WakeLoad;
        end
      end
      // A wake always runs to completion regardless of REQ.
      StWake: begin
        if (wake_cnt_q == '0) begin
          state_d = StActive;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      StActive: begin
        if (!REQ) begin
          state_d    = StHold;
          idle_cnt_d = IdleLoad;
        end
      end
      // REQ is checked first so a late request beats expiry of the hold-off.
      StHold: begin
        if (REQ) begin
          state_d    = StActive;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == '0) begin
          state_d = StGated;
        end else begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end
      end
      default: state_d = StGated;
    endcase
  end

  // Outputs are registered from next state so every output is a flop.
  always_comb begin
    clk_en_d = (state_d != StGated) || FORCE_ON;
    rdy_d    = (state_d == StActive) || (state_d == StHold);
    gate_inc = (state_q == StHold) && (state_d == StGated);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StGated;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      clk_en_q   <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      clk_en_q   <= clk_en_d;
      rdy_q      <= rdy_d;
    end
  end

  sat_counter u_gate_cnt (
    .CLK (CLK),
    .RST (RST),
    .INC (gate_inc),
    .CNT (GATE_CNT)
  );

  assign CLK_EN = clk_en_q;
  assign RDY    = rdy_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (WAKE_CYC=2, IDLE_CYC=8) plus a standalone saturation run.
module tb_clk_gate_ctrl;

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic        FORCE_ON;
  logic        CLK_EN;
  logic        RDY;
  logic [15:0] GATE_CNT;
  logic        sat_inc;
  logic [15:0] sat_cnt;

  int n_checks;
  int n_fail;

  clk_gate_ctrl #(
    .WAKE_CYC (2),
    .IDLE_CYC (8)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .FORCE_ON (FORCE_ON),
    .CLK_EN   (CLK_EN),
    .RDY      (RDY),
    .GATE_CNT (GATE_CNT)
  );

  sat_counter u_sat (
    .CLK (CLK),
    .RST (RST),
    .INC (sat_inc),
    .CNT (sat_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Mid-cycle async reset pulse; outputs must clear before the next edge.
  task automatic reset_pulse(input string tag);
    #2;
    RST = 1'b1;
    #1;
    check_eq({tag, "_clk_en"}, 32'(CLK_EN), 32'd0);
    check_eq({tag, "_rdy"}, 32'(RDY), 32'd0);
    check_eq({tag, "_gate_cnt"}, 32'(GATE_CNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    REQ      = 1'b0;
    FORCE_ON = 1'b0;
    sat_inc  = 1'b0;

    tick(2);
    check_eq("rst_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("rst_rdy", 32'(RDY), 32'd0);
    check_eq("rst_gate_cnt", 32'(GATE_CNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick(2);
    check_eq("idle_gated_clk_en", 32'(CLK_EN), 32'd0);

    // Wake: enable after edge k, ready after edge k+2.
    REQ = 1'b1;
    tick(1);
    check_eq("wake_k_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("wake_k_rdy", 32'(RDY), 32'd0);
    tick(1);
    check_eq("wake_k1_rdy", 32'(RDY), 32'd0);
    tick(1);
    check_eq("wake_k2_rdy", 32'(RDY), 32'd1);
    check_eq("wake_k2_clk_en", 32'(CLK_EN), 32'd1);
    tick(3);

    // Idle gating: 8 held cycles, gated after the 9th edge.
    REQ = 1'b0;
    tick(1);
    check_eq("hold_e0_rdy", 32'(RDY), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check_eq($sformatf("hold_e%0d_clk_en", i), 32'(CLK_EN), 32'd1);
    end
    tick(1);
    check_eq("gate_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("gate_rdy", 32'(RDY), 32'd0);
    check_eq("gate_cnt_1", 32'(GATE_CNT), 32'd1);

    // Re-request during hold.
    REQ = 1'b1;
    tick(3);
    check_eq("rereq_wake_rdy", 32'(RDY), 32'd1);
    REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq($sformatf("rereq_hold%0d_clk_en", i), 32'(CLK_EN), 32'd1);
    end
    REQ = 1'b1;
    tick(1);
    check_eq("rereq_rdy", 32'(RDY), 32'd1);
    tick(8);
    check_eq("rereq_late_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("rereq_gate_cnt", 32'(GATE_CNT), 32'd1);

    // Boundary: REQ returns exactly on the edge the hold counter would expire.
    REQ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_eq($sformatf("bnd_hold%0d_clk_en", i), 32'(CLK_EN), 32'd1);
    end
    REQ = 1'b1;
    tick(1);
    check_eq("bnd_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("bnd_rdy", 32'(RDY), 32'd1);
    check_eq("bnd_gate_cnt", 32'(GATE_CNT), 32'd1);
    tick(2);
    check_eq("bnd_after_rdy", 32'(RDY), 32'd1);
    REQ = 1'b0;
    tick(9);
    check_eq("bnd_gate_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("bnd_gate_cnt_2", 32'(GATE_CNT), 32'd2);

    // A one-cycle request still completes the wake.
    REQ = 1'b1;
    tick(1);
    check_eq("pulse_wake_clk_en", 32'(CLK_EN), 32'd1);
    REQ = 1'b0;
    tick(1);
    check_eq("pulse_wake_k1_rdy", 32'(RDY), 32'd0);
    check_eq("pulse_wake_k1_clk_en", 32'(CLK_EN), 32'd1);
    tick(1);
    check_eq("pulse_active_rdy", 32'(RDY), 32'd1);
    tick(9);
    check_eq("pulse_gate_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("pulse_gate_cnt_3", 32'(GATE_CNT), 32'd3);

    // Override in GATED.
    FORCE_ON = 1'b1;
    #1;
    check_eq("force_no_comb_path", 32'(CLK_EN), 32'd0);
    tick(1);
    check_eq("force_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("force_rdy", 32'(RDY), 32'd0);
    tick(3);
    check_eq("force_hold_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("force_hold_rdy", 32'(RDY), 32'd0);
    FORCE_ON = 1'b0;
    tick(1);
    check_eq("force_release_clk_en", 32'(CLK_EN), 32'd0);

    // Override does not block state transitions or counting.
    FORCE_ON = 1'b1;
    REQ      = 1'b1;
    tick(3);
    check_eq("force_wake_rdy", 32'(RDY), 32'd1);
    REQ = 1'b0;
    tick(9);
    check_eq("force_gate_rdy", 32'(RDY), 32'd0);
    check_eq("force_gate_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("force_gate_cnt_4", 32'(GATE_CNT), 32'd4);
    FORCE_ON = 1'b0;
    tick(1);
    check_eq("force_gate_release", 32'(CLK_EN), 32'd0);

    // Reset mid-WAKE, then first sample on the first edge after release.
    REQ = 1'b1;
    tick(1);
    check_eq("pre_rst_wake_clk_en", 32'(CLK_EN), 32'd1);
    reset_pulse("rst_wake");
    tick(1);
    check_eq("post_rst_wake_clk_en", 32'(CLK_EN), 32'd1);
    check_eq("post_rst_wake_rdy", 32'(RDY), 32'd0);
    tick(2);
    check_eq("post_rst_active_rdy", 32'(RDY), 32'd1);

    // Reset mid-HOLD: no gating count survives or is added.
    REQ = 1'b0;
    tick(9);
    check_eq("pre_rst_gate_cnt_1", 32'(GATE_CNT), 32'd1);
    REQ = 1'b1;
    tick(3);
    REQ = 1'b0;
    tick(3);
    check_eq("pre_rst_hold_rdy", 32'(RDY), 32'd1);
    reset_pulse("rst_hold");
    tick(12);
    check_eq("post_rst_hold_clk_en", 32'(CLK_EN), 32'd0);
    check_eq("post_rst_hold_gate_cnt", 32'(GATE_CNT), 32'd0);

    // Saturation of the gate counter.
    check_eq("sat_start", 32'(sat_cnt), 32'd0);
    sat_inc = 1'b1;
    tick(65534);
    check_eq("sat_fffe", 32'(sat_cnt), 32'h0000_FFFE);
    tick(1);
    check_eq("sat_ffff", 32'(sat_cnt), 32'h0000_FFFF);
    tick(5);
    check_eq("sat_hold", 32'(sat_cnt), 32'h0000_FFFF);
    sat_inc = 1'b0;
    tick(2);
    check_eq("sat_idle", 32'(sat_cnt), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
